// File: rtl/burst_framer.sv
// rtl/burst_framer.sv - frames bursts from the ping-pong buffer into sync/seq/len/payload/csum packets
module burst_framer #(
    parameter int         BURST_MAX = 1024,
    parameter int         FIFO_AW   = 11,
    parameter int         DESC_AW   = 2,
    parameter logic [7:0] SYNC0     = 8'hA5,
    parameter logic [7:0] SYNC1     = 8'h5A
) (
    input  logic        clk_rd,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  din,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  dout,
    output logic        out_sop,
    output logic        out_eop,
    output logic        overflow,
    output logic [15:0] frame_cnt
);
    localparam int LW     = $clog2(BURST_MAX + 1);
    localparam int DW     = LW + 8;
    localparam int FDEPTH = 1 << FIFO_AW;
    localparam int DDEPTH = 1 << DESC_AW;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_SEQ, S_LENH, S_LENL, S_DATA, S_CSUM
    } state_t;

    logic [7:0]         data_mem [FDEPTH];
    logic [FIFO_AW-1:0] data_wp, data_rp;
    logic [FIFO_AW:0]   data_cnt;
    logic [DW-1:0]      desc_mem [DDEPTH];
    logic [DESC_AW-1:0] desc_wp, desc_rp;
    logic [DESC_AW:0]   desc_cnt;

    logic               in_burst, burst_ok;
    logic [LW-1:0]      len;
    logic [7:0]         csum;

    state_t             state;
    logic [LW-1:0]      cur_len, remaining;
    logic [7:0]         cur_csum, seq;
    logic [15:0]        len16;

    logic data_full, desc_full, desc_empty, burst_start, burst_end;
    logic byte_ok, desc_push, xfer, data_rd;

    assign data_full   = data_cnt == (FIFO_AW+1)'(FDEPTH);
    assign desc_full   = desc_cnt == (DESC_AW+1)'(DDEPTH);
    assign desc_empty  = desc_cnt == '0;
    assign burst_start = in_valid && !in_burst;
    assign burst_end   = !in_valid && in_burst;
    // Admission is decided on the first byte and then holds for the whole run
    assign byte_ok     = in_valid && (burst_start ? !desc_full : burst_ok)
                         && !data_full && (len != LW'(BURST_MAX));
    assign desc_push   = burst_end && burst_ok;
    assign xfer        = out_valid && out_ready;
    assign data_rd     = xfer && ((state == S_LENL && cur_len != '0) ||
                                  (state == S_DATA && remaining != '0));
    assign len16       = 16'(cur_len);

    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            in_burst <= 1'b0;
            burst_ok <= 1'b0;
            len      <= '0;
            csum     <= '0;
            overflow <= 1'b0;
        end else begin
            in_burst <= in_valid;
            if (burst_start)
                burst_ok <= !desc_full;
            if (burst_end) begin
                len  <= '0;
                csum <= '0;
            end else if (byte_ok) begin
                len  <= len + 1'b1;
                csum <= csum + din;
            end
            if (in_valid && !byte_ok)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_rd) begin
        if (byte_ok)
            data_mem[data_wp] <= din;
        if (desc_push)
            desc_mem[desc_wp] <= {len, csum};
    end

    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            data_wp  <= '0;
            data_rp  <= '0;
            data_cnt <= '0;
            desc_wp  <= '0;
            desc_rp  <= '0;
            desc_cnt <= '0;
        end else begin
            if (byte_ok)
                data_wp <= data_wp + 1'b1;
            if (data_rd)
                data_rp <= data_rp + 1'b1;
            case ({byte_ok, data_rd})
                2'b10:   data_cnt <= data_cnt + 1'b1;
                2'b01:   data_cnt <= data_cnt - 1'b1;
                default: data_cnt <= data_cnt;
            endcase
            if (desc_push)
                desc_wp <= desc_wp + 1'b1;
            if (state == S_IDLE && !desc_empty)
                desc_rp <= desc_rp + 1'b1;
            case ({desc_push, state == S_IDLE && !desc_empty})
                2'b10:   desc_cnt <= desc_cnt + 1'b1;
                2'b01:   desc_cnt <= desc_cnt - 1'b1;
                default: desc_cnt <= desc_cnt;
            endcase
        end
    end

    // Outputs change only on a completed transfer, so they hold through stalls
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            seq       <= '0;
            frame_cnt <= '0;
            cur_len   <= '0;
            cur_csum  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: if (!desc_empty) begin
                    {cur_len, cur_csum} <= desc_mem[desc_rp];
                    state     <= S_HDR0;
                    out_valid <= 1'b1;
                    dout      <= SYNC0;
                    out_sop   <= 1'b1;
                end
                S_HDR0: if (xfer) begin
                    state   <= S_HDR1;
                    dout    <= SYNC1;
                    out_sop <= 1'b0;
                end
                S_HDR1: if (xfer) begin
                    state <= S_SEQ;
                    dout  <= seq;
                end
                S_SEQ: if (xfer) begin
                    state <= S_LENH;
                    dout  <= len16[15:8];
                end
                S_LENH: if (xfer) begin
                    state <= S_LENL;
                    dout  <= len16[7:0];
                end
                S_LENL: if (xfer) begin
                    if (cur_len != '0) begin
                        state     <= S_DATA;
                        dout      <= data_mem[data_rp];
                        remaining <= cur_len - 1'b1;
                    end else begin
                        state   <= S_CSUM;
                        dout    <= cur_csum;
                        out_eop <= 1'b1;
                    end
                end
                S_DATA: if (xfer) begin
                    if (remaining != '0) begin
                        dout      <= data_mem[data_rp];
                        remaining <= remaining - 1'b1;
                    end else begin
                        state   <= S_CSUM;
                        dout    <= cur_csum;
                        out_eop <= 1'b1;
                    end
                end
                S_CSUM: if (xfer) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_eop   <= 1'b0;
                    seq       <= seq + 1'b1;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/burst_framer.md
# burst_framer

Downstream stage of the ping-pong RAM buffer, clocked in the read domain. Consumes the buffer's bursty byte stream (valid strobe plus byte, no backpressure) and emits each burst as a framed packet over a ready/valid interface. Frame layout: sync word, sequence number, length, payload and checksum. Internal buffering absorbs the burst while the consumer stalls.

## Interface
- BURST_MAX, 1024: max payload bytes per frame; bytes beyond this are dropped
- FIFO_AW, 11: data FIFO address width (2^FIFO_AW bytes)
- DESC_AW, 2: descriptor FIFO address width (2^DESC_AW frames pending)
- SYNC0, 8'hA5: first header byte
- SYNC1, 8'h5A: second header byte
- clk_rd  in  1  single clock (read-domain clock of the ping-pong buffer)
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  byte strobe from ping-pong buffer (out_valid there)
- din  in  8  payload byte, sampled when in_valid=1
- out_ready  in  1  downstream accepts byte
- out_valid  out  1  dout holds a frame byte
- dout  out  8  frame byte
- out_sop  out  1  high with the SYNC0 byte
- out_eop  out  1  high with the checksum byte
- overflow  out  1  sticky drop indicator
- frame_cnt  out  16  frames fully transferred, wraps at 16'hFFFF→0

## Operation
- Burst: maximal run of consecutive cycles with in_valid=1. Burst end = first cycle in_valid=0 after a 1.
- Frame, in order: SYNC0, SYNC1, seq[7:0], len[15:8], len[7:0], len payload bytes, csum. Total len+6 bytes.
- Input side: each accepted byte is written to the data FIFO. len is incremented and csum is updated as csum = (csum + din) mod 256.
- At burst end, descriptor {len, csum} is pushed. len and csum are then cleared.
- Admission: a burst is accepted only if the descriptor FIFO is not full in its first cycle. Otherwise the whole burst is dropped and overflow=1.
- A byte is dropped (not written, not counted in len/csum, overflow=1) when:
  - the data FIFO is full, or
  - len has already reached BURST_MAX.
- Output FSM: IDLE → HDR0 → HDR1 → SEQ → LENH → LENL → DATA → CSUM → IDLE.
  - IDLE→HDR0 when the descriptor FIFO is non-empty; the descriptor is popped.
  - Every other state advances on out_valid & out_ready.
  - DATA stays for len transfers.
  - CSUM → IDLE on transfer; at that transfer seq and frame_cnt increment.
- Data FIFO is show-ahead, so DATA emits one byte per cycle with no bubbles while out_ready=1.
- Simultaneous events:
  - Data FIFO write and read in the same cycle: both occur, occupancy unchanged.
  - Descriptor push and pop in the same cycle: both occur.
- overflow clears only on rst.
- Reset values: out_valid=0, dout=0, out_sop=0, out_eop=0, overflow=0, frame_cnt=0, seq=0, FSM=IDLE, both FIFOs empty, len=0, csum=0.
- Reset mid-operation: partial frame and all buffered data are discarded. The first frame after reset carries seq=00.

## Timing
- All outputs are registered.
- Latency, idle FSM: in_valid sampled low at edge k pushes the descriptor. At edge k+1 the FSM enters HDR0, so out_valid=1 with SYNC0 after edge k+1.
- With out_ready held at 1, a frame occupies exactly len+6 consecutive cycles. The next frame's SYNC0 follows CSUM after at most 1 IDLE cycle.
- Handshake rules:
  - When out_valid=1 and out_ready=0, dout, out_sop and out_eop hold unchanged.
  - out_valid never drops before the transfer.
- out_ready is ignored while out_valid=0.
- Input is never stalled. The block accepts in_valid every cycle at full rate.
- len is 16 bits on the wire; internal length counter is clog2(BURST_MAX+1) bits, zero-extended.

## Test plan
- 4-byte burst 01 02 03 04, out_ready=1.
  - Required dout: A5 5A 00 00 04 01 02 03 04 0A over 10 consecutive cycles.
  - out_sop on A5, out_eop on 0A; frame_cnt=1.
- 1024-byte burst of ramp 00..FF ×4, out_ready=1 → header A5 5A 00 04 00, 1024 ramp bytes, csum 00; overflow=0.
- Burst of 1027 bytes → len 04 00, only the first 1024 bytes framed, overflow=1.
- Test 1 stimulus with out_ready alternating 1,0 → identical byte sequence; dout/sop/eop stable in every stalled cycle.
- Backlog: bursts 11 22 and 33 separated by 1 idle cycle, out_ready=0 until both end.
  - Required: frames A5 5A 00 00 02 11 22 33 then A5 5A 01 00 01 33 33; frame_cnt=2.
- Reset: rst pulsed mid-DATA of a 16-byte frame → out_valid=0 immediately, frame_cnt=0. Next burst 7F frames as A5 5A 00 00 01 7F 7F.
